// File: rtl/ram_fifo_ctrl.sv
// Purpose : first-word-fall-through FIFO controller in front of a simple dual-port block RAM.
// Latency : a write into an empty FIFO is fetched one edge later and shows on rd_valid two edges later.
// Backpres: rd_ready low lets the 2-entry output buffer fill, then fetching stops and the RAM absorbs writes
//           until full; writes while full are dropped and flagged by a one-cycle overflow pulse.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   wr_en, wr_data           producer side; full / overflow report the RAM region state
//   rd_valid, rd_ready,      consumer side valid/ready stream, rd_data is the head word
//   rd_data
//   count                    words held in RAM + in-flight read + output buffer (0..DEPTH+2)
//   ram_we, ram_waddr,       RAM write port
//   ram_din
//   ram_raddr, ram_dout      RAM read port; dout is valid the cycle after raddr was sampled

module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  overflow,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,

    output logic [ADDR_WIDTH+1:0] count,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // Pointers carry one extra bit so that a completely full RAM (difference
    // of DEPTH) is distinguishable from an empty one (difference of 0).
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH+1:0] CNT_ONE   = {{(ADDR_WIDTH+1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;

    logic                  push;
    logic                  pop;
    logic                  fetch;

    // pend: a read address was sampled by the RAM at the last edge, so the
    // word is on ram_dout now and must be captured at the coming edge.
    logic                  pend;

    // Two-entry output buffer; ob_head is always the oldest word.
    logic [1:0]            ob_cnt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic [DATA_WIDTH-1:0] ob_tail;

    // Occupancy of the output buffer after this edge if nothing new is
    // fetched: current entries, plus the word being captured, minus the pop.
    logic [2:0]            ob_after;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign ram_cnt   = wr_ptr - rd_ptr;
    assign full      = (ram_cnt == DEPTH_CNT);
    assign push      = wr_en & ~full;

    // Held low during reset so a pending wr_en cannot scribble on the RAM.
    assign ram_we    = push & ~rst;
    assign ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_din   = wr_data;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign rd_valid  = (ob_cnt != 2'd0);
    assign rd_data   = ob_head;
    assign pop       = rd_valid & rd_ready;

    assign ob_after  = {1'b0, ob_cnt} + {2'b00, pend} - {2'b00, pop};

    // Only issue a read when the word it returns is guaranteed a slot in the
    // output buffer one edge later; this lets capture be unconditional.
    assign fetch     = (ram_cnt != '0) & (ob_after < 3'd2);

    // The RAM samples this every edge; when fetch is low the read result is
    // simply not captured.
    assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend     <= 1'b0;
            ob_cnt   <= 2'd0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            overflow <= wr_en & full;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            pend   <= fetch;
            ob_cnt <= ob_after[1:0];

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output buffer data. No reset needed: contents are only observed
    // while ob_cnt says they are valid, and reset clears ob_cnt and pend.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pop) begin
            // Head leaves; the next-oldest word moves up. If the buffer held
            // only the head, the captured word becomes the new head.
            if (pend && (ob_cnt == 2'd1)) begin
                ob_head <= ram_dout;
            end else begin
                ob_head <= ob_tail;
            end
            if (pend && (ob_cnt == 2'd2)) begin
                ob_tail <= ram_dout;
            end
        end else if (pend) begin
            // Append behind whatever is already queued.
            if (ob_cnt == 2'd0) begin
                ob_head <= ram_dout;
            end else begin
                ob_tail <= ram_dout;
            end
        end
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

First-word-fall-through FIFO controller that drives our simple dual-port block RAM (one write port, registered read address, data valid one cycle after the address edge). It generates RAM write/read addresses and strobes, tracks occupancy, and hides the RAM read latency behind a 2-entry output buffer, so the consumer sees a valid/ready stream at one word per cycle. It sits directly upstream of the RAM instance, and the two together form the team's standard buffered channel.

## Interface
- ADDR_WIDTH, 10, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 8, word width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- full  out  1  RAM region full; wr_en ignored while high
- overflow  out  1  one-cycle pulse: wr_en while full
- rd_valid  out  1  rd_data holds head word
- rd_ready  in  1  consumer accepts head word
- rd_data  out  DATA_WIDTH  head word
- count  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer), max DEPTH+2
- ram_we  out  1  to RAM we
- ram_waddr  out  ADDR_WIDTH  to RAM waddr
- ram_din  out  DATA_WIDTH  to RAM din
- ram_raddr  out  ADDR_WIDTH  to RAM raddr (sampled by RAM each edge)
- ram_dout  in  DATA_WIDTH  from RAM dout, valid the cycle after ram_raddr was sampled

## Operation
- Pointers wr_ptr, rd_ptr: ADDR_WIDTH+1 bits, wrap mod 2*DEPTH; ram_cnt = wr_ptr - rd_ptr (0..DEPTH).
- Write: push = wr_en & ~full. ram_we = push, ram_waddr = wr_ptr[ADDR_WIDTH-1:0], ram_din = wr_data; wr_ptr += push.
- full = (ram_cnt == DEPTH). overflow registered: = wr_en & full.
- Fetch: ram_raddr = rd_ptr[ADDR_WIDTH-1:0] always. fetch = (ram_cnt != 0) & (ob_cnt + pend - pop < 2). On fetch: rd_ptr += 1, pend <= 1; else pend <= 0.
- pend: a word read last edge, present on ram_dout this cycle; it is captured into output buffer at the next edge (unconditionally, space guaranteed by fetch rule).
- Output buffer: 2-entry in-order queue, ob_cnt 0..2. rd_valid = (ob_cnt != 0); rd_data = head entry. pop = rd_valid & rd_ready.
- Simultaneous pop and capture: head removed, captured word appended; order preserved.
- count: +1 on push, -1 on pop, net 0 when both.
- rd_ready while rd_valid low: no effect. Write while full: dropped, overflow pulse, no state change.
- Fetch frees a RAM slot; full deasserts the following cycle (no same-cycle write-through while full).
- RAM contents never cleared; stale data is unreachable after reset.

## Timing
- Reset values (after rst edge): full 0, overflow 0, rd_valid 0, count 0, ram_we 0 (forced low while rst high), ram_raddr 0, ram_waddr 0, pointers 0, pend 0, ob_cnt 0. rd_data undefined while rd_valid 0.
- rst mid-operation: all in-flight, buffered and RAM words discarded; a fetch outstanding at reset is not captured.
- Write-to-read latency into empty FIFO: write at edge N, fetch at edge N+1, rd_valid high after edge N+2.
- Steady-state throughput: 1 word/cycle with wr_en and rd_ready held high.
- Capacity: DEPTH+2 words (DEPTH in RAM, up to 2 in pend/output buffer); full reflects RAM region only.
- Consumer stall with rd_ready low: ob fills to 2, fetch stops, RAM absorbs further writes.

## Test plan
- Reset: assert rst 2 cycles with wr_en=1 -> ram_we 0, count 0, rd_valid 0, full 0; no word appears after release.
- Latency: ADDR_WIDTH=4, write 0xA5 at edge N into empty FIFO, rd_ready=0 -> rd_valid rises after edge N+2, rd_data 0xA5, count 1.
- Streaming: write 0..63 back-to-back with rd_ready=1 -> read sequence 0..63 in order, no bubble after first word, count peaks at 3.
- Full/overflow: ADDR_WIDTH=4, rd_ready=0, write 20 words -> 18 accepted (16 RAM + 2 buffer), full high, count 18, overflow pulses on writes 19 and 20; drain reads words 0..17 exactly.
- Wrap: ADDR_WIDTH=2, 100 words with random wr_en/rd_ready -> output equals input order, count never exceeds 6.
- Reset mid-stream: 5 words held, fetch pending, rst pulse -> count 0, rd_valid 0; next written 0x3C is the first word read.
